// File: rtl/mult_booth_param.sv
// Sequential radix-2 Booth multiplier producing a full 2*WIDTH-bit product in hi/lo, signed or unsigned.
// Optional overflow flag output ovf is built only when MULT_OVF_EN is defined.
module mult_booth_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             comeco,
  input  logic             sinal,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ocupado,
  output logic             pronto,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
`ifdef MULT_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       state_dbg
);

  localparam int AW = 2 * WIDTH + 3;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIM  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     m;
  logic [AW-1:0]      acc;
  logic [WIDTH:0]     p_hi;
  logic [WIDTH:0]     p_sum;
  logic [AW-1:0]      acc_step;
  logic [2*WIDTH-1:0] prod;
`ifdef MULT_OVF_EN
  logic               sgn;
`endif

  // handshake: comeco is sampled only in IDLE; ocupado is high while Booth
  // steps run; pronto pulses for one cycle when hi/lo take the new result
  assign ocupado   = (state == RUN);
  assign state_dbg = state;
  assign prod      = acc[2*WIDTH:1];

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (comeco) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = FIM;
      FIM:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // accumulator layout is {P_hi, P_lo, q_-1}; one Booth add/sub then arithmetic shift
  always_comb begin
    p_hi = acc[AW-1 -: WIDTH+1];
    unique case (acc[1:0])
      2'b01:   p_sum = p_hi + m;
      2'b10:   p_sum = p_hi - m;
      default: p_sum = p_hi;
    endcase
    acc_step = {p_sum[WIDTH], p_sum, acc[WIDTH+1:1]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      m      <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
      pronto <= 1'b0;
`ifdef MULT_OVF_EN
      sgn    <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      pronto <= 1'b0;
      unique case (state)
        IDLE: begin
          if (comeco) begin
            // one WIDTH+1-bit datapath covers both modes via the extension bit
            m   <= {sinal & a[WIDTH-1], a};
            acc <= {{(WIDTH+1){1'b0}}, sinal & b[WIDTH-1], b, 1'b0};
            cnt <= '0;
`ifdef MULT_OVF_EN
            sgn <= sinal;
`endif
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        FIM: begin
          hi     <= prod[2*WIDTH-1:WIDTH];
          lo     <= prod[WIDTH-1:0];
          pronto <= 1'b1;
`ifdef MULT_OVF_EN
          if (sgn) ovf <= (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
          else     ovf <= (prod[2*WIDTH-1:WIDTH] != '0);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_booth_param.sv
// Bench for mult_booth_param: a 32-bit and an 8-bit instance checked against an arithmetic product model.
// Covers ovf as well when MULT_OVF_EN is defined.
module tb_mult_booth_param;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  logic          comeco, sinal, ocupado, pronto;
  logic [W-1:0]  a, b, hi, lo;
  logic [1:0]    state_dbg;
  logic          comeco8, sinal8, ocupado8, pronto8;
  logic [7:0]    a8, b8, hi8, lo8;
  logic [1:0]    state_dbg8;
`ifdef MULT_OVF_EN
  logic          ovf, ovf8;
`endif

  mult_booth_param #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .comeco(comeco), .sinal(sinal),
    .a(a), .b(b), .ocupado(ocupado), .pronto(pronto), .hi(hi), .lo(lo),
`ifdef MULT_OVF_EN
    .ovf(ovf),
`endif
    .state_dbg(state_dbg)
  );

  mult_booth_param #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .comeco(comeco8), .sinal(sinal8),
    .a(a8), .b(b8), .ocupado(ocupado8), .pronto(pronto8), .hi(hi8), .lo(lo8),
`ifdef MULT_OVF_EN
    .ovf(ovf8),
`endif
    .state_dbg(state_dbg8)
  );

  // monitors: busy cycles and pronto pulses seen on the falling edge
  int busy_cnt = 0;
  int pronto_cnt = 0;
  always @(negedge clock) begin
    if (ocupado === 1'b1) busy_cnt++;
    if (pronto === 1'b1) pronto_cnt++;
  end

  // scoreboard: {ovf, hi, lo}
  logic [64:0] exp_q[$];
  logic [64:0] last_exp;
  int checks = 0;
  int failures = 0;
  int t_start = 0;
  int busy_base = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // exact product of the operands as integers, plus whether it fits in w bits
  function automatic logic [64:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic s, input int w);
    logic signed [66:0] xs, ys, p, lim;
    logic o;
    xs  = s ? $signed({{35{x[31]}}, x}) : $signed({35'b0, x});
    ys  = s ? $signed({{35{y[31]}}, y}) : $signed({35'b0, y});
    p   = xs * ys;
    lim = 67'sd1 <<< (s ? w - 1 : w);
    o   = s ? ((p >= lim) || (p < -lim)) : (p >= lim);
    return {o, p[63:0]};
  endfunction

  // drivers
  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic s);
    a = x; b = y; sinal = s; comeco = 1'b1;
    exp_q.push_back(ref_mul(x, y, s, W));
    @(posedge clock);
    #1;
    comeco = 1'b0;
    t_start = cyc;
    busy_base = busy_cnt;
  endtask

  task automatic wait_done(input string tag);
    int n;
    logic [64:0] e;
    n = 0;
    while (pronto !== 1'b1 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({tag, "_lat"}, 64'(cyc - t_start), 64'(LAT));
    check({tag, "_busy"}, 64'(busy_cnt - busy_base), 64'(W + 1));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    last_exp = e;
    check({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
    check({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
`ifdef MULT_OVF_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(e[64]));
`endif
  endtask

  task automatic idle_check(input string tag);
    @(posedge clock);
    #1;
    check({tag, "_pulse"}, 64'(pronto), 64'(0));
    check({tag, "_hold"}, {hi, lo}, last_exp[63:0]);
  endtask

  task automatic mul8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [64:0] e;
    int t0, n;
    e = ref_mul(s ? {{24{x[7]}}, x} : {24'b0, x}, s ? {{24{y[7]}}, y} : {24'b0, y}, s, 8);
    a8 = x; b8 = y; sinal8 = s; comeco8 = 1'b1;
    @(posedge clock);
    #1;
    comeco8 = 1'b0;
    t0 = cyc;
    n = 0;
    while (pronto8 !== 1'b1 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({tag, "_lat"}, 64'(cyc - t0), 64'(10));
    check({tag, "_hi"}, 64'(hi8), 64'(e[15:8]));
    check({tag, "_lo"}, 64'(lo8), 64'(e[7:0]));
`ifdef MULT_OVF_EN
    check({tag, "_ovf"}, 64'(ovf8), 64'(e[64]));
`endif
  endtask

  initial begin
    logic [31:0] x, y;
    logic s;
    int pbase;

    reset = 1'b1; comeco = 1'b0; sinal = 1'b0; a = '0; b = '0;
    comeco8 = 1'b0; sinal8 = 1'b0; a8 = '0; b8 = '0;
    #1;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_flags", {62'd0, ocupado, pronto}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // signed small operands, latency and busy window
    start_op(32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_done("t1");
    idle_check("t1");

    // edge operands
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done("t2_uones");
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("t2_sones");
    start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done("t2_minneg");
    idle_check("t2");

    // operand changes and start requests while busy are ignored
    start_op(32'd5, 32'd6, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock);
      #1;
      if (k >= 3) begin
        a = 32'h0000_FFFF; b = 32'h0000_FFFF; comeco = 1'b1;
      end
    end
    comeco = 1'b0;
    wait_done("t3_busy");
    // back-to-back start in the pronto cycle
    start_op(32'd2, 32'd3, 1'b0);
    wait_done("t3_b2b");

    // asynchronous reset in flight discards the result
    start_op(32'd7, 32'd9, 1'b0);
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("t4_rst_hilo", {hi, lo}, 64'd0);
    check("t4_rst_flags", {62'd0, ocupado, pronto}, 64'd0);
    exp_q.delete();
    pbase = pronto_cnt;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    check("t4_no_pronto", 64'(pronto_cnt - pbase), 64'd0);
    start_op(32'd4, 32'd4, 1'b0);
    wait_done("t4_after");

    // overflow-flag vectors (result checks apply in both builds)
    start_op(32'h0001_0000, 32'h0001_0000, 1'b1);
    wait_done("t6_big");
    start_op(32'hFFFF_FFFF, 32'd1, 1'b1);
    wait_done("t6_sneg1");
    start_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done("t6_uones");

    // 8-bit instance
    mul8("t5_s", 8'h80, 8'hFF, 1'b1);
    mul8("t5_u", 8'h80, 8'hFF, 1'b0);
    mul8("t5_smin", 8'h80, 8'h80, 1'b1);
    for (int i = 0; i < 6; i++) begin
      mul8("r8", 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // randomized 32-bit operations
    for (int i = 0; i < 16; i++) begin
      x = $urandom;
      y = $urandom;
      s = 1'($urandom_range(0, 1));
      if (i % 5 == 1) x = 32'h8000_0000;
      if (i % 7 == 2) y = 32'hFFFF_FFFF;
      start_op(x, y, s);
      wait_done("rnd");
      if (i % 4 == 3) idle_check("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
